// File: rtl/fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fc_layer_sequencer
// Description : Time-multiplexed fully connected layer. Computes
//               out_j = sat((bias_j + sum_i in_i*w_ji) >>> FRAC_BITS)
//               with one MAC per cycle from a single-read-port weight/bias
//               memory. Results stream out over a valid/ready handshake.
// Ports       : clk, rst_n      - clock, synchronous active-low reset
//               start, in_vec   - begin a layer / input vector (latched)
//               busy            - high whenever not idle
//               w_rd_en, w_addr - memory read strobe and address
//               w_data          - read data, valid one cycle after w_rd_en
//               out_valid, out_ready, out_data, out_idx - result stream
//               done            - one-cycle pulse after the last neuron
// Options     : define FC_RELU_EN to clamp negative results to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_layer_sequencer #(
    parameter int  IN        = 1,
    parameter int  OUT       = 1,
    parameter int  DATA_SIZE = 8,
    parameter int  FRAC_BITS = 0,
    parameter int  ADDR_W    = ($clog2(IN*OUT+OUT) > 1) ? $clog2(IN*OUT+OUT) : 1,
    localparam int IDX_W     = (OUT > 1) ? $clog2(OUT) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [IN*DATA_SIZE-1:0]     in_vec,
    output logic                        busy,
    output logic                        w_rd_en,
    output logic [ADDR_W-1:0]           w_addr,
    input  logic signed [DATA_SIZE-1:0] w_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [DATA_SIZE-1:0] out_data,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        done
);

    localparam int ACC_W = 2*DATA_SIZE + $clog2(IN+1);
    localparam int I_W   = (IN > 1) ? $clog2(IN) : 1;

    localparam logic [ADDR_W-1:0]       c_BIAS_BASE = ADDR_W'(IN*OUT);
    localparam logic [I_W-1:0]          c_I_LAST    = I_W'(IN-1);
    localparam logic [IDX_W-1:0]        c_J_LAST    = IDX_W'(OUT-1);
    localparam logic signed [ACC_W-1:0] c_SAT_MAX   =
        {{(ACC_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_SAT_MIN   =
        {{(ACC_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BIAS  = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    state_t                      r_state, w_state_nxt;
    logic signed [DATA_SIZE-1:0] r_in [IN];
    logic [I_W-1:0]              r_i, w_i_nxt;
    logic [IDX_W-1:0]            r_j, w_j_nxt;
    logic [ADDR_W-1:0]           r_wptr, w_wptr_nxt;
    logic [ADDR_W-1:0]           r_addr, w_addr_nxt;
    logic signed [ACC_W-1:0]     r_acc, w_acc_nxt;
    logic                        r_busy, r_rd_en, r_valid, r_done;
    logic                        w_rd_nxt, w_valid_nxt, w_done_nxt;
    logic                        w_latch, w_res_load;
    logic signed [DATA_SIZE-1:0] r_data, w_res;
    logic [IDX_W-1:0]            r_idx;

    // Datapath: the word returning this cycle belongs to the read issued in
    // the previous cycle, so the input it multiplies is one index behind.
    logic [I_W-1:0]              w_mul_sel;
    logic signed [2*DATA_SIZE-1:0] w_prod;
    logic signed [ACC_W-1:0]     w_prod_ext, w_bias_ext, w_sum, w_shift;

    assign w_mul_sel  = (r_state == S_DRAIN) ? c_I_LAST : (r_i - I_W'(1));
    assign w_prod     = (2*DATA_SIZE)'(r_in[w_mul_sel]) * (2*DATA_SIZE)'(w_data);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_bias_ext = ACC_W'(w_data);
    assign w_sum      = r_acc + w_prod_ext;
    assign w_shift    = w_sum >>> FRAC_BITS;

    always_comb begin
        w_res = w_shift[DATA_SIZE-1:0];
        if (w_shift > c_SAT_MAX) begin
            w_res = c_SAT_MAX[DATA_SIZE-1:0];
        end else if (w_shift < c_SAT_MIN) begin
            w_res = c_SAT_MIN[DATA_SIZE-1:0];
        end
`ifdef FC_RELU_EN
        if (w_res[DATA_SIZE-1]) begin
            w_res = '0;
        end
`else
`endif
    end

    // Next-state and next-output logic. Outputs are registered from the
    // next-state values so they line up with the state they belong to.
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_wptr_nxt  = r_wptr;
        w_addr_nxt  = r_addr;
        w_acc_nxt   = r_acc;
        w_rd_nxt    = 1'b0;
        w_valid_nxt = r_valid;
        w_done_nxt  = 1'b0;
        w_latch     = 1'b0;
        w_res_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_latch     = 1'b1;
                    w_j_nxt     = '0;
                    w_wptr_nxt  = '0;
                    w_rd_nxt    = 1'b1;
                    w_addr_nxt  = c_BIAS_BASE;
                    w_state_nxt = S_BIAS;
                end
            end
            S_BIAS: begin
                w_i_nxt     = '0;
                w_rd_nxt    = 1'b1;
                w_addr_nxt  = r_wptr;
                w_wptr_nxt  = r_wptr + ADDR_W'(1);
                w_state_nxt = S_MAC;
            end
            S_MAC: begin
                // First return of a neuron is its bias; the rest are weights.
                w_acc_nxt = (r_i == '0) ? w_bias_ext : w_sum;
                if (r_i == c_I_LAST) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_i_nxt    = r_i + I_W'(1);
                    w_rd_nxt   = 1'b1;
                    w_addr_nxt = r_wptr;
                    w_wptr_nxt = r_wptr + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                w_acc_nxt   = w_sum;
                w_res_load  = 1'b1;
                w_valid_nxt = 1'b1;
                w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_valid_nxt = 1'b0;
                    if (r_j == c_J_LAST) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_j_nxt     = r_j + IDX_W'(1);
                        w_rd_nxt    = 1'b1;
                        w_addr_nxt  = c_BIAS_BASE + ADDR_W'(w_j_nxt);
                        w_state_nxt = S_BIAS;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i     <= '0;
            r_j     <= '0;
            r_wptr  <= '0;
            r_addr  <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_rd_en <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            for (int k = 0; k < IN; k++) begin
                r_in[k] <= '0;
            end
        end else begin
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_wptr  <= w_wptr_nxt;
            r_addr  <= w_addr_nxt;
            r_acc   <= w_acc_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_rd_en <= w_rd_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            if (w_res_load) begin
                r_data <= w_res;
                r_idx  <= r_j;
            end
            if (w_latch) begin
                for (int k = 0; k < IN; k++) begin
                    r_in[k] <= in_vec[k*DATA_SIZE +: DATA_SIZE];
                end
            end
        end
    end

    assign busy      = r_busy;
    assign w_rd_en   = r_rd_en;
    assign w_addr    = r_addr;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_layer_sequencer
// Description : Self-checking bench for fc_layer_sequencer. Instance A is a
//               4-input, 2-neuron integer layer; instance B is a 2-input,
//               1-neuron layer with FRAC_BITS=4. Expected results come from
//               a plain-arithmetic reference of the layer equation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_layer_sequencer;

    localparam int D      = 8;
    localparam int A_IN   = 4;
    localparam int A_OUT  = 2;
    localparam int A_AW   = 4;
    localparam int B_IN   = 2;
    localparam int B_OUT  = 1;
    localparam int B_AW   = 2;
    localparam int B_FRAC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              a_start = 1'b0;
    logic [A_IN*D-1:0] a_in_vec = '0;
    logic              a_busy, a_w_rd_en, a_out_valid, a_done;
    logic [A_AW-1:0]   a_w_addr;
    logic [D-1:0]      a_w_data = '0;
    logic              a_out_ready = 1'b0;
    logic [D-1:0]      a_out_data;
    logic [0:0]        a_out_idx;

    logic              b_start = 1'b0;
    logic [B_IN*D-1:0] b_in_vec = '0;
    logic              b_busy, b_w_rd_en, b_out_valid, b_done;
    logic [B_AW-1:0]   b_w_addr;
    logic [D-1:0]      b_w_data = '0;
    logic              b_out_ready = 1'b0;
    logic [D-1:0]      b_out_data;
    logic [0:0]        b_out_idx;

    fc_layer_sequencer #(.IN(A_IN), .OUT(A_OUT), .DATA_SIZE(D), .FRAC_BITS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .in_vec(a_in_vec),
        .busy(a_busy), .w_rd_en(a_w_rd_en), .w_addr(a_w_addr), .w_data(a_w_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_idx(a_out_idx), .done(a_done)
    );

    fc_layer_sequencer #(.IN(B_IN), .OUT(B_OUT), .DATA_SIZE(D), .FRAC_BITS(B_FRAC)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_vec(b_in_vec),
        .busy(b_busy), .w_rd_en(b_w_rd_en), .w_addr(b_w_addr), .w_data(b_w_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_idx(b_out_idx), .done(b_done)
    );

    int in_a [16];
    int mem_a [16];
    int in_b [16];
    int mem_b [16];
    int exp_a [16];
    int n_tests = 0;
    int n_fail  = 0;

    // Memories answer one cycle after a read; junk otherwise.
    always @(posedge clk) begin
        a_w_data <= a_w_rd_en ? D'(mem_a[a_w_addr]) : D'($urandom);
        b_w_data <= b_w_rd_en ? D'(mem_b[b_w_addr]) : D'($urandom);
    end

    task automatic check_value(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: bias + dot product, arithmetic shift, saturate, optional ReLU.
    function automatic int ref_out(input int inv[16], input int mem[16], input int n_in,
                                   input int n_out, input int j, input int frac);
        longint acc;
        acc = longint'(mem[n_in*n_out + j]);
        for (int i = 0; i < n_in; i++) acc += longint'(inv[i]) * longint'(mem[j*n_in + i]);
        acc = acc >>> frac;
        if (acc > longint'((1 << (D-1)) - 1)) acc = longint'((1 << (D-1)) - 1);
        if (acc < -longint'(1 << (D-1)))      acc = -longint'(1 << (D-1));
`ifdef FC_RELU_EN
        if (acc < 0) acc = 0;
`else
`endif
        return int'(acc);
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(255)) - 128;
    endfunction

    task automatic load_a();
        for (int i = 0; i < A_IN; i++) a_in_vec[i*D +: D] = D'(in_a[i]);
        for (int j = 0; j < A_OUT; j++) exp_a[j] = ref_out(in_a, mem_a, A_IN, A_OUT, j, 0);
    endtask

    task automatic run_a(input string tag, input int ready_pct, input int stall_n,
                         input bit glitch, input bit chain, input bit skip_start,
                         input bit chk_timing);
        int cyc, first_v, done_c, n_out, stall_left, k;
        bit rdy, got_done;
        int addr_q[$];
        if (!skip_start) begin
            a_start = 1'b1;
            tick();
            a_start = 1'b0;
        end
        check_value({tag, "_busy"}, a_busy, 1);
        cyc = 0; first_v = -1; done_c = -1; n_out = 0; stall_left = stall_n; got_done = 0;
        while (!got_done && cyc < 400) begin
            if (a_w_rd_en) addr_q.push_back(int'(a_w_addr));
            if (a_done) begin
                got_done = 1'b1;
                done_c   = cyc;
            end
            rdy = (int'($urandom_range(99)) < ready_pct);
            if (a_out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end
                if (n_out < A_OUT) begin
                    check_value({tag, "_data"}, longint'($signed(a_out_data)), exp_a[n_out]);
                    check_value({tag, "_idx"}, a_out_idx, n_out);
                end else begin
                    check_value({tag, "_extra_valid"}, 1, 0);
                end
                check_value({tag, "_rden_in_emit"}, a_w_rd_en, 0);
                if (rdy) n_out++;
            end
            a_start = (chain && got_done);
            if (glitch && cyc == 2) begin
                a_start = 1'b1;
                for (int i = 0; i < A_IN; i++) a_in_vec[i*D +: D] = D'(rnd8());
            end
            a_out_ready = rdy;
            tick();
            cyc++;
        end
        a_start     = 1'b0;
        a_out_ready = 1'b0;
        check_value({tag, "_done_seen"}, got_done, 1);
        check_value({tag, "_n_out"}, n_out, A_OUT);
        check_value({tag, "_n_addr"}, addr_q.size(), A_OUT*(A_IN+1));
        k = 0;
        for (int j = 0; j < A_OUT; j++) begin
            if (k < addr_q.size()) check_value({tag, "_addr"}, addr_q[k], A_IN*A_OUT + j);
            k++;
            for (int i = 0; i < A_IN; i++) begin
                if (k < addr_q.size()) check_value({tag, "_addr"}, addr_q[k], j*A_IN + i);
                k++;
            end
        end
        if (chk_timing) begin
            check_value({tag, "_first_valid_lat"}, first_v, A_IN + 2);
            check_value({tag, "_done_lat"}, done_c, A_OUT*(A_IN + 3));
        end
        if (chain) begin
            check_value({tag, "_chain_busy"}, a_busy, 1);
            check_value({tag, "_chain_rden"}, a_w_rd_en, 1);
        end else begin
            check_value({tag, "_done_pulse"}, a_done, 0);
            check_value({tag, "_idle_busy"}, a_busy, 0);
        end
    endtask

    task automatic run_b(input string tag);
        int cyc, e;
        e = ref_out(in_b, mem_b, B_IN, B_OUT, 0, B_FRAC);
        for (int i = 0; i < B_IN; i++) b_in_vec[i*D +: D] = D'(in_b[i]);
        b_out_ready = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        cyc = 0;
        while (!b_out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check_value({tag, "_lat"}, cyc, B_IN + 2);
        check_value({tag, "_data"}, longint'($signed(b_out_data)), e);
        check_value({tag, "_idx"}, b_out_idx, 0);
        tick();
        check_value({tag, "_done"}, b_done, 1);
        check_value({tag, "_valid_low"}, b_out_valid, 0);
        tick();
        check_value({tag, "_done_pulse"}, b_done, 0);
        b_out_ready = 1'b0;
    endtask

    task automatic check_a_zero(input string tag);
        check_value({tag, "_busy"}, a_busy, 0);
        check_value({tag, "_rden"}, a_w_rd_en, 0);
        check_value({tag, "_valid"}, a_out_valid, 0);
        check_value({tag, "_done"}, a_done, 0);
        check_value({tag, "_addr"}, a_w_addr, 0);
        check_value({tag, "_data"}, a_out_data, 0);
        check_value({tag, "_idx"}, a_out_idx, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            in_a[i] = 0; mem_a[i] = 0; in_b[i] = 0; mem_b[i] = 0; exp_a[i] = 0;
        end

        rst_n = 1'b0;
        tick();
        tick();
        check_a_zero("reset");
        check_value("reset_b_busy", b_busy, 0);
        check_value("reset_b_valid", b_out_valid, 0);
        rst_n = 1'b1;
        tick();

        // Basic layer: expects 20 and -7.
        in_a[0:3]  = '{1, 2, 3, 4};
        mem_a[0:3] = '{1, 1, 1, 1};
        mem_a[4:7] = '{-1, 0, 2, -3};
        mem_a[8]   = 10;
        mem_a[9]   = 0;
        load_a();
        run_a("basic", 100, 0, 0, 0, 0, 1);
        run_a("backpressure", 100, 5, 0, 0, 0, 0);
        load_a();
        run_a("start_busy", 100, 0, 1, 0, 0, 1);
        load_a();
        run_a("b2b_first", 100, 0, 0, 1, 0, 1);
        run_a("b2b_second", 100, 0, 0, 0, 1, 1);

        // Reset during the MAC phase of neuron 1.
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_out_ready = 1'b1;
        repeat (9) tick();
        check_value("pre_reset_rden", a_w_rd_en, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a_out_ready = 1'b0;
        check_a_zero("mid_reset");
        tick();
        check_a_zero("post_reset");
        run_a("after_reset", 100, 0, 0, 0, 0, 1);

        // Saturation on both rails.
        for (int i = 0; i < A_IN; i++) begin
            in_a[i] = 127; mem_a[i] = 127; mem_a[A_IN + i] = -128;
        end
        mem_a[8] = 127;
        mem_a[9] = -128;
        load_a();
        run_a("saturate", 100, 0, 0, 0, 0, 1);

        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < A_IN; i++) in_a[i] = rnd8();
            for (int i = 0; i < A_IN*A_OUT + A_OUT; i++) mem_a[i] = rnd8();
            load_a();
            run_a("random", int'($urandom_range(30, 100)), 0, 0, 0, 0, 0);
        end

        // Fixed point: 1.0*2.0 + 2.0*1.0 = 4.0 -> 64.
        in_b[0:1]  = '{16, 32};
        mem_b[0:2] = '{32, 16, 0};
        run_b("fixed_point");
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < B_IN; i++) in_b[i] = rnd8();
            for (int i = 0; i < B_IN + 1; i++) mem_b[i] = rnd8();
            run_b("fixed_random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fc_layer_sequencer.md
Name: fc_layer_sequencer

Overview:
- Time-multiplexed controller and datapath for one fully connected layer: out_j = sat(bias_j + sum_i in_i*w_ji).
- Latches an input vector on start, then walks a single-read-port weight/bias memory one MAC per cycle.
- Accumulates at full precision and streams each neuron result out over a valid/ready handshake.
- Sits between the previous layer's output register and the next layer's input buffer; replaces the fully combinational layer where area matters.

Parameters:
IN, 1, input vector length (>=1)
OUT, 1, number of neurons (>=1)
DATA_SIZE, 8, signed width of inputs, weights, biases, outputs
FRAC_BITS, 0, arithmetic right shift applied to the accumulator before saturation (0..DATA_SIZE)
ADDR_W, $clog2(IN*OUT+OUT) (min 1), weight memory address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin layer; sampled only in IDLE
in_vec  in  IN*DATA_SIZE  signed inputs, element i at [i*DATA_SIZE +: DATA_SIZE]; latched when start is accepted
busy  out  1  high whenever not in IDLE
w_rd_en  out  1  memory read strobe
w_addr  out  ADDR_W  read address: weight j,i at j*IN+i; bias j at IN*OUT+j
w_data  in  DATA_SIZE  signed read data, valid exactly 1 cycle after w_rd_en
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_data  out  DATA_SIZE  signed saturated result
out_idx  out  $clog2(OUT) (min 1)  neuron index j of out_data
done  out  1  one-cycle pulse after the last neuron is accepted

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE. busy, w_rd_en, out_valid and done are 0. w_addr, out_data and out_idx are 0. Accumulator and indices are 0. Any in-flight layer is discarded; a memory response arriving after reset is ignored.
- All outputs are registered.
- Accumulator width: ACC_W = 2*DATA_SIZE + $clog2(IN+1). All products and sums are signed and sign-extended to ACC_W; there is no overflow inside the accumulator.
- FSM:
  - IDLE: on start=1, latch in_vec, set j=0, go to BIAS. start while busy is ignored.
  - BIAS: w_rd_en=1, w_addr=IN*OUT+j. Go to MAC with i=0.
  - MAC: w_rd_en=1, w_addr=j*IN+i. The returning word is added: the first return loads acc=sext(bias); later returns do acc += in_{i-1}*w. Increment i. After issuing i=IN-1, go to DRAIN.
  - DRAIN: w_rd_en=0. Accumulate the last product. Compute res = acc>>>FRAC_BITS, clamp to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1]. Register out_data=res and out_idx=j, set out_valid=1, go to EMIT.
  - EMIT: hold out_valid, out_data and out_idx stable, with no memory reads, until out_valid&&out_ready. On the handshake:
    - if j<OUT-1: out_valid=0, j++, go to BIAS;
    - else: out_valid=0, done=1 for one cycle, go to IDLE.
- Latency: out_valid rises IN+2 edges after the edge that accepts start. With out_ready held high, each neuron takes IN+3 cycles and the layer takes OUT*(IN+3).
- start is accepted in the same cycle that done is high, since the state is already IDLE.
- in_vec changes after acceptance have no effect.
- IN=1 and OUT=1 must work; MAC lasts one cycle.

Optional Feature:
FC_RELU_EN
- Defined: after saturation, negative results are replaced by 0 before being registered into out_data.
- Undefined: signed saturated result is emitted unchanged.
- Latency is identical either way.

Test Plan:
- Basic layer. Setup: IN=4, OUT=2, DATA_SIZE=8, FRAC_BITS=0, in=[1,2,3,4], w0=[1,1,1,1], b0=10, w1=[-1,0,2,-3], b1=0, out_ready=1. Expected:
  - out (idx0)=20, out (idx1)=-7;
  - first out_valid 6 edges after start;
  - done 14 cycles after start;
  - address sequence 8,0,1,2,3,9,4,5,6,7.
- Saturation. Setup: in all 127, w0 all 127, b0=127 -> 127. Setup: w1 all -128, b1=-128 -> -128. With FC_RELU_EN defined, the second result is 0.
- Backpressure. Setup: out_ready=0 for 5 cycles at the first EMIT. Expected: out_valid high, out_data=20 and out_idx=0 stable, w_rd_en=0 throughout; neuron 1 proceeds after out_ready=1.
- Busy and back-to-back start. Stimulus: start pulsed during MAC. Expected: ignored, results unchanged. Stimulus: start held high at done. Expected: new layer accepted that cycle, with busy staying high.
- Reset mid-layer. Stimulus: rst_n=0 for 1 cycle during MAC of neuron 1. Expected: all outputs 0 and state IDLE; a new start yields the correct 20 and -7.
- Fixed point. Setup: FRAC_BITS=4, in=[16,32] (1.0, 2.0), w0=[32,16], b0=0. Expected: acc=1024 -> out=64.
